// File: rtl/pc_pkg.sv
// Shared types for the program counter: control-op encoding, its priority decode and
// default sizing.
package pc_pkg;

    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_DEPTH  = 4;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_SKIP,
        PC_JUMP,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Strobes are resolved ret > call > jump > skip > increment; a stall holds everything.
    function automatic pc_op_e pc_op_decode(input logic enable, input logic ret,
                                            input logic call, input logic jump,
                                            input logic skip);
        pc_op_e op;
        if (!enable)   op = PC_HOLD;
        else if (ret)  op = PC_RET;
        else if (call) op = PC_CALL;
        else if (jump) op = PC_JUMP;
        else if (skip) op = PC_SKIP;
        else           op = PC_INC;
        return op;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// DEPTH x ADDR_W return-address LIFO. push and pop are never requested together;
// a push while full or a pop while empty is ignored.
module ret_stack
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned SP_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [ADDR_W-1:0] stack_d [DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    assign wr_idx   = IDX_W'(sp_q);
    assign rd_idx   = IDX_W'(sp_q - SP_W'(1));
    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);
    assign sp       = sp_q;
    // Only meaningful when not empty; callers gate on that.
    assign top_data = stack_q[rd_idx];

    always_comb begin
        stack_d = stack_q;
        sp_d    = sp_q;
        if (push && !full) begin
            stack_d[wr_idx] = push_data;
            sp_d            = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) sp_q <= '0;
        else        sp_q <= sp_d;
    end

    // Entry contents need no reset: they are only read below a valid sp.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with jump, call/return through ret_stack and sticky overflow/underflow
// flags. Define PC_SKIP_EN to add the skip input (pc += 2 at lowest strobe priority).
module pc_stack
    import pc_pkg::*;
#(
    parameter int unsigned        ADDR_W     = DEF_ADDR_W,
    parameter int unsigned        DEPTH      = DEF_DEPTH,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
    localparam int unsigned       SP_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
`ifdef PC_SKIP_EN
    input  logic              skip,
`endif
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic [SP_W-1:0]   sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              overflow,
    output logic              underflow
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [ADDR_W-1:0] pc_inc, top_data;
    logic              skip_w, push, pop;
    pc_op_e            op;

`ifdef PC_SKIP_EN
    assign skip_w = skip;
`else
    assign skip_w = 1'b0;
`endif

    assign op     = pc_op_decode(enable, ret, call, jump, skip_w);
    assign pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        pc_d        = pc_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push        = 1'b0;
        pop         = 1'b0;
        unique case (op)
            PC_HOLD: pc_d = pc_q;
            PC_INC:  pc_d = pc_inc;
            PC_SKIP: pc_d = pc_q + ADDR_W'(2);
            PC_JUMP: pc_d = target;
            PC_CALL: begin
                // The branch is taken even when the return address cannot be saved.
                pc_d = target;
                if (stack_full) overflow_d = 1'b1;
                else            push       = 1'b1;
            end
            PC_RET: begin
                if (stack_empty) begin
                    underflow_d = 1'b1;
                    pc_d        = pc_inc;
                end else begin
                    pop  = 1'b1;
                    pc_d = top_data;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_ADDR;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    ret_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .sp        (sp),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign pc        = pc_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack (ADDR_W=12, DEPTH=4, RESET_ADDR=0) with hand-computed
// expectations; skip vectors are included when PC_SKIP_EN is defined.
module tb_pc_stack;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SP_W   = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n, enable, jump, call, ret;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic              stack_full, stack_empty, overflow, underflow;
`ifdef PC_SKIP_EN
    logic              skip;
`endif

    int vectors    = 0;
    int miscompares = 0;

    pc_stack #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .RESET_ADDR (12'h000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .jump        (jump),
        .call        (call),
        .ret         (ret),
`ifdef PC_SKIP_EN
        .skip        (skip),
`endif
        .target      (target),
        .pc          (pc),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply strobes, clock once, sample 1 time unit after the edge.
    task automatic step(input logic en, input logic r, input logic c, input logic j,
                        input logic [ADDR_W-1:0] t);
        enable = en; ret = r; call = c; jump = j; target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [ADDR_W-1:0] exp_pc,
                               input int exp_sp, input logic exp_ovf, input logic exp_unf);
        check({tag, ".pc"}, 32'(pc), 32'(exp_pc));
        check({tag, ".sp"}, 32'(sp), 32'(exp_sp));
        check({tag, ".full"}, 32'(stack_full), 32'(exp_sp == DEPTH));
        check({tag, ".empty"}, 32'(stack_empty), 32'(exp_sp == 0));
        check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ".unf"}, 32'(underflow), 32'(exp_unf));
    endtask

    initial begin
        rst_n = 1'b0;
`ifdef PC_SKIP_EN
        skip = 1'b0;
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_state("reset", 12'h000, 0, 1'b0, 1'b0);

        // Plain increment
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("inc1.pc", 32'(pc), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("inc2.pc", 32'(pc), 32'h2);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_state("inc3", 12'h003, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("at5.pc", 32'(pc), 32'h5);

        // Call / return round trip
        step(1'b1, 1'b0, 1'b1, 1'b0, 12'h100);
        check_state("call100", 12'h100, 1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("sub.pc", 32'(pc), 32'h102);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_state("ret6", 12'h006, 0, 1'b0, 1'b0);

        // Nested calls to overflow
        step(1'b1, 1'b0, 1'b0, 1'b1, 12'h010);
        check("jump10.pc", 32'(pc), 32'h010);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 12'h200 + 12'(i));
            check_state($sformatf("nest%0d", i), 12'h200 + 12'(i), (i < 4) ? i + 1 : 4,
                        i == 4, 1'b0);
        end

        // Unwind: returns 0x203, 0x202, 0x201, 0x011, then underflow
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_state("unw1", 12'h203, 3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_state("unw2", 12'h202, 2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_state("unw3", 12'h201, 1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_state("unw4", 12'h011, 0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_state("unw5", 12'h012, 0, 1'b1, 1'b1);

        // Wrap-around of increment and pushed return address
        step(1'b1, 1'b0, 1'b0, 1'b1, 12'hFFF);
        check("atFFF.pc", 32'(pc), 32'hFFF);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("wrap.pc", 32'(pc), 32'h000);
        step(1'b1, 1'b0, 1'b0, 1'b1, 12'hFFF);
        step(1'b1, 1'b0, 1'b1, 1'b0, 12'h300);
        check_state("callFFF", 12'h300, 1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_state("retwrap", 12'h000, 0, 1'b1, 1'b1);

        // ret beats call and jump
        step(1'b1, 1'b0, 1'b1, 1'b0, 12'h050);
        check_state("call50", 12'h050, 1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 12'h777);
        check_state("prio", 12'h001, 0, 1'b1, 1'b1);

        // Stall ignores strobes
        step(1'b0, 1'b0, 1'b1, 1'b0, 12'h600);
        check_state("stall_call", 12'h001, 0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h600);
        check("stall_jump.pc", 32'(pc), 32'h001);

        // Reset during a call at sp=2
        step(1'b1, 1'b0, 1'b1, 1'b0, 12'h400);
        step(1'b1, 1'b0, 1'b1, 1'b0, 12'h410);
        check_state("presreset", 12'h410, 2, 1'b1, 1'b1);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 12'h500);
        check_state("midreset", 12'h000, 0, 1'b0, 1'b0);
        rst_n = 1'b1;

`ifdef PC_SKIP_EN
        step(1'b1, 1'b0, 1'b0, 1'b1, 12'hFFE);
        skip = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("skipwrap.pc", 32'(pc), 32'h000);
        step(1'b1, 1'b0, 1'b0, 1'b1, 12'h040);
        check("skipjump.pc", 32'(pc), 32'h040);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("skip2.pc", 32'(pc), 32'h042);
        skip = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter with jump, subroutine call/return and a return-address stack.
- Successor to the plain incrementing PC in the sequencer front end.
- Its output addresses instruction fixed memory each cycle; control decode drives jump/call/ret strobes.
- Stack overflow/underflow are reported as sticky flags for the simulator's alarm logic.

Parameters:
- ADDR_W, 12, width of PC, target and stack entries.
- DEPTH, 4, return-address stack entries (>=1).
- RESET_ADDR, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- enable  input  1  advance PC this cycle; low = hold everything (stall).
- jump  input  1  load target.
- call  input  1  push return address, load target.
- ret  input  1  pop stack into PC.
- target  input  ADDR_W  jump/call destination.
- pc  output  ADDR_W  current instruction address (registered).
- sp  output  $clog2(DEPTH+1)  number of valid stack entries.
- stack_full  output  1  sp == DEPTH (combinational from sp).
- stack_empty  output  1  sp == 0 (combinational from sp).
- overflow  output  1  sticky: call attempted while full.
- underflow  output  1  sticky: ret attempted while empty.

Behaviour:
- All state updates on the rising edge of clk; all outputs registered or decoded from registers.
- Reset (rst_n low at the edge) overrides everything:
  - pc=RESET_ADDR, sp=0, overflow=0, underflow=0; stack contents don't-care.
  - Mid-operation reset discards any pending call/ret.
- enable=0: pc, sp, stack and flags hold; jump/call/ret/skip are ignored.
- enable=1, priority ret > call > jump > increment; only the winner acts.
  - ret, sp>0: pc<=stack[sp-1], sp<=sp-1.
  - ret, sp==0: underflow<=1, pc<=pc+1 (treated as no-op instruction), sp stays 0.
  - call, sp<DEPTH: stack[sp]<=pc+1, sp<=sp+1, pc<=target.
  - call, sp==DEPTH: overflow<=1, no push, pc<=target (jump still taken), sp unchanged.
  - jump: pc<=target.
  - none: pc<=pc+1.
- Arithmetic is modulo 2^ADDR_W:
  - pc all-ones increments to 0.
  - call at pc all-ones pushes 0.
- Latency: a strobe sampled at edge N is reflected on pc after edge N; one cycle, no bubbles.
- Flags clear only on reset.

Optional Feature:
- Macro: PC_SKIP_EN.
- Defined: extra input skip (1 bit), lowest priority above increment.
  - enable=1, skip=1, no ret/call/jump: pc<=pc+2 (modulo, wraps).
  - Used for conditional-skip instructions.
- Undefined: no skip port; behaviour exactly as above.

Decomposition:
- Shared package pc_pkg holds:
  - PC control op enum (PC_HOLD, PC_INC, PC_SKIP, PC_JUMP, PC_CALL, PC_RET), encoded by a priority function.
  - Default ADDR_W/DEPTH localparams.
- One natural sub-module, ret_stack: DEPTH x ADDR_W LIFO with push/pop, sp, full/empty.
  - Push and pop are never asserted together (guaranteed by the priority decode).
- pc_stack holds the PC register, op decode and sticky flags.

Test Plan:
- Reset then enable=1, no strobes, 3 cycles -> pc 0,1,2,3; sp=0; stack_empty=1.
- At pc=5, call target=0x100 -> pc=0x100, sp=1; 2 increments then ret -> pc=6, sp=0.
- DEPTH=4: five nested calls to 0x200..0x204 from pc=0x010:
  - Fifth call -> overflow=1, pc=0x204, sp=4.
  - Four rets then a fifth ret -> underflow=1, pc increments.
- pc=0xFFF no strobe -> pc=0x000; call at 0xFFF -> pushed return address 0x000.
- Simultaneous ret+call+jump with sp=1 -> ret wins.
- Call with enable=0 -> pc and sp unchanged.
- rst_n low during a call cycle at sp=2 -> pc=RESET_ADDR, sp=0, flags 0.
- PC_SKIP_EN: pc=0xFFE, skip=1 -> pc=0x000; skip+jump target=0x40 -> pc=0x40.
